ula: RTL and testbench

Small 4-bit arithmetic unit. It takes two unsigned 4-bit operands and a 4-bit operation selector, computes add, subtract, multiply, divide or remainder, and presents an 8-bit result through an output register. It sits between the switch/operand input stage and the display or result-consumer logic. It is a single-clock block with no handshake: the result follows the inputs with one cycle of latency.

---
 rtl/ula_pkg.sv | 22 ++
 rtl/ula_div.sv | 38 +++
 rtl/ula.sv | 67 ++++++
 tb/tb_ula.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/ula_pkg.sv
// Shared opcode constants, widths and the registered result bundle of the ula arithmetic unit.
package ula_pkg;

    localparam int OPND_W = 4;
    localparam int RES_W  = 8;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_MUL = 4'b0010;
    localparam logic [3:0] OP_DIV = 4'b0011;
    localparam logic [3:0] OP_MOD = 4'b0100;

    typedef struct packed {
        logic [RES_W-1:0] saida;
        logic             div_zero;
    } ula_res_t;

    function automatic logic [RES_W-1:0] zext(input logic [OPND_W-1:0] v);
        return {{(RES_W-OPND_W){1'b0}}, v};
    endfunction

endpackage

// File: rtl/ula_div.sv
// Combinational 4-bit restoring divider; a zero divisor yields zero outputs and raises by_zero.
module ula_div
    import ula_pkg::*;
(
    input  logic [OPND_W-1:0] dividend,
    input  logic [OPND_W-1:0] divisor,
    output logic [OPND_W-1:0] quotient,
    output logic [OPND_W-1:0] remainder,
    output logic              by_zero
);

    logic [OPND_W:0]   part_rem;
    logic [OPND_W-1:0] quot_raw;

    always_comb begin
        part_rem = '0;
        quot_raw = '0;
        // Shift in one dividend bit per step, subtract when the divisor fits.
        for (int i = OPND_W - 1; i >= 0; i--) begin
            part_rem = {part_rem[OPND_W-1:0], dividend[i]};
            if (part_rem >= {1'b0, divisor}) begin
                part_rem    = part_rem - {1'b0, divisor};
                quot_raw[i] = 1'b1;
            end
        end
    end

    always_comb begin
        by_zero   = (divisor == '0);
        quotient  = '0;
        remainder = '0;
        if (!by_zero) begin
            quotient  = quot_raw;
            remainder = part_rem[OPND_W-1:0];
        end
    end

endmodule

// File: rtl/ula.sv
// 4-bit arithmetic unit with one-cycle registered result. Divide/remainder exist only when ULA_DIV_EN is defined.
module ula
    import ula_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          switchs,
    input  logic [OPND_W-1:0]   A,
    input  logic [OPND_W-1:0]   B,
    output logic [RES_W-1:0]    saida,
    output logic                div_zero
);

    logic [RES_W-1:0] a_ext;
    logic [RES_W-1:0] b_ext;
    ula_res_t         res_d;
    ula_res_t         res_q;

    assign a_ext = zext(A);
    assign b_ext = zext(B);

`ifdef ULA_DIV_EN
    logic [OPND_W-1:0] quot;
    logic [OPND_W-1:0] rem;
    logic              by_zero;

    ula_div u_div (
        .dividend  (A),
        .divisor   (B),
        .quotient  (quot),
        .remainder (rem),
        .by_zero   (by_zero)
    );
`endif

    always_comb begin
        res_d = '0;
        case (switchs)
            OP_ADD: res_d.saida = a_ext + b_ext;
            OP_SUB: res_d.saida = a_ext - b_ext;
            OP_MUL: res_d.saida = a_ext * b_ext;
`ifdef ULA_DIV_EN
            OP_DIV: begin
                res_d.saida    = zext(quot);
                res_d.div_zero = by_zero;
            end
            OP_MOD: begin
                res_d.saida    = zext(rem);
                res_d.div_zero = by_zero;
            end
`endif
            default: res_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_q <= '0;
        end else begin
            res_q <= res_d;
        end
    end

    assign saida    = res_q.saida;
    assign div_zero = res_q.div_zero;

endmodule

// File: tb/tb_ula.sv
// Directed scoreboard bench for ula; expected results come from an independent arithmetic model.
module tb_ula;

    logic       clk;
    logic       rst;
    logic [3:0] switchs;
    logic [3:0] A;
    logic [3:0] B;
    logic [7:0] saida;
    logic       div_zero;

    typedef struct {
        logic [7:0] saida;
        logic       dz;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    ula dut (
        .clk      (clk),
        .rst      (rst),
        .switchs  (switchs),
        .A        (A),
        .B        (B),
        .saida    (saida),
        .div_zero (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
        exp_t e;
        int ai;
        int bi;
        ai = a;
        bi = b;
        e.saida = 8'h00;
        e.dz = 1'b0;
        case (op)
            4'd0: e.saida = 8'((ai + bi) % 256);
            4'd1: e.saida = 8'((ai - bi + 256) % 256);
            4'd2: e.saida = 8'(ai * bi);
`ifdef ULA_DIV_EN
            4'd3: if (bi == 0) e.dz = 1'b1; else e.saida = 8'(ai / bi);
            4'd4: if (bi == 0) e.dz = 1'b1; else e.saida = 8'(ai % bi);
`endif
            default: ;
        endcase
        return e;
    endfunction

    task automatic drive(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
        switchs = op;
        A = a;
        B = b;
        sb.push_back(model(op, a, b));
    endtask

    task automatic check_now(input string tag, input logic [7:0] exp_s, input logic exp_dz);
        checks++;
        assert ({saida, div_zero} === {exp_s, exp_dz}) else begin
            errors++;
            $error("FAIL %s: observed saida=%h div_zero=%b expected saida=%h div_zero=%b",
                   tag, saida, div_zero, exp_s, exp_dz);
        end
    endtask

    task automatic check_sb(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: observed empty scoreboard expected a pending result", tag);
        end else begin
            e = sb.pop_front();
            check_now(tag, e.saida, e.dz);
        end
    endtask

    task automatic step(input string tag, input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
        @(negedge clk);
        drive(op, a, b);
        @(posedge clk);
        #1;
        check_sb(tag);
    endtask

    // Fixed literal checks straight from the expected-value table.
    task automatic step_lit(input string tag, input logic [3:0] op, input logic [3:0] a,
                            input logic [3:0] b, input logic [7:0] exp_s, input logic exp_dz);
        @(negedge clk);
        switchs = op;
        A = a;
        B = b;
        @(posedge clk);
        #1;
        check_now(tag, exp_s, exp_dz);
    endtask

    logic [3:0] ops [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};

    initial begin
        rst = 1'b0;
        switchs = 4'b0000;
        A = 4'd4;
        B = 4'd1;
        #2;
        rst = 1'b1;
        #1;
        check_now("reset_async", 8'h00, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        sb.push_back(model(4'b0000, 4'd4, 4'd1));
        @(posedge clk);
        #1;
        check_sb("reset_release");

        // Asynchronous clear between edges, then reload on the first edge.
        #2;
        rst = 1'b1;
        #1;
        check_now("reset_midstream", 8'h00, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_now("reset_reload", 8'h05, 1'b0);

        step_lit("add_0_0",   4'd0, 4'd0,  4'd0,  8'h00, 1'b0);
        step_lit("add_4_1",   4'd0, 4'd4,  4'd1,  8'h05, 1'b0);
        step_lit("add_8_15",  4'd0, 4'd8,  4'd15, 8'h17, 1'b0);
        step_lit("add_15_15", 4'd0, 4'd15, 4'd15, 8'h1E, 1'b0);
        step_lit("sub_8_4",   4'd1, 4'd8,  4'd4,  8'h04, 1'b0);
        step_lit("sub_2_3",   4'd1, 4'd2,  4'd3,  8'hFF, 1'b0);
        step_lit("sub_1_4",   4'd1, 4'd1,  4'd4,  8'hFD, 1'b0);
        step_lit("sub_4_4",   4'd1, 4'd4,  4'd4,  8'h00, 1'b0);
        step_lit("mul_8_0",   4'd2, 4'd8,  4'd0,  8'h00, 1'b0);
        step_lit("mul_8_8",   4'd2, 4'd8,  4'd8,  8'h40, 1'b0);
        step_lit("mul_15_1",  4'd2, 4'd15, 4'd1,  8'h0F, 1'b0);
        step_lit("mul_15_15", 4'd2, 4'd15, 4'd15, 8'hE1, 1'b0);
`ifdef ULA_DIV_EN
        step_lit("div_8_2",   4'd3, 4'd8,  4'd2,  8'h04, 1'b0);
        step_lit("div_2_2",   4'd3, 4'd2,  4'd2,  8'h01, 1'b0);
        step_lit("div_9_1",   4'd3, 4'd9,  4'd1,  8'h09, 1'b0);
        step_lit("div_1_0",   4'd3, 4'd1,  4'd0,  8'h00, 1'b1);
        step_lit("mod_9_4",   4'd4, 4'd9,  4'd4,  8'h01, 1'b0);
        step_lit("mod_7_0",   4'd4, 4'd7,  4'd0,  8'h00, 1'b1);
`else
        step_lit("div_off_8_2", 4'd3, 4'd8, 4'd2, 8'h00, 1'b0);
        step_lit("mod_off_7_0", 4'd4, 4'd7, 4'd0, 8'h00, 1'b0);
`endif
        step_lit("reserved_0111", 4'd7,  4'd9,  4'd3, 8'h00, 1'b0);
        step_lit("reserved_1111", 4'd15, 4'd15, 4'd0, 8'h00, 1'b0);

        // Input glitches between edges must not reach the registered output.
        @(negedge clk);
        drive(4'd2, 4'd3, 4'd5);
        #2;
        A = 4'd15;
        #1;
        check_now("hold_between_edges", 8'h00, 1'b0);
        A = 4'd3;
        @(posedge clk);
        #1;
        check_sb("hold_after_edge");

        // Back-to-back issue cycling through every op, including zero divisors.
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 5; k++) begin
                step($sformatf("b2b_r%0d_op%0d", r, k), ops[k],
                     4'($urandom_range(0, 15)), (r == 2) ? 4'd0 : 4'($urandom_range(1, 15)));
            end
        end
        for (int k = 0; k < 16; k++) begin
            step($sformatf("rand_%0d", k), 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
